mfp_usart_tx: RTL

//  Transmitter half of the MFP68901 USART. Serialises bytes written to UDR.
//  Bit rate comes from timer D's T_O output, which is wired to TC_I.

---
 rtl/mfp_usart_tx.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mfp_usart_tx.sv
// -----------------------------------------------------------------------------
// mfp_usart_tx
//   Transmitter half of the MFP68901 USART. Bytes written to UDR are held in a
//   one-deep buffer, then serialised as asynchronous frames: a start bit, 5-8
//   data bits LSB first, an optional parity bit, and 1, 1.5 or 2 stop bits.
//   The bit rate comes from timer D's T_O output on TC_I. That clock is either
//   used directly or divided by DIV.
//
// Parameters
//   DIV       bit-clock divisor used when UCR_I[7]=1 (power of two, 2..16)
//
// Ports
//   XCLK_I    in   1  clock (MFP timer clock)
//   RST       in   1  synchronous, active-high reset
//   TC_I      in   1  transmit clock level from timer D, asynchronous
//   UCR_I     in   8  [7] div-by-DIV, [6:5] word length (00=8 .. 11=5),
//                     [4:3] stop bits (0x=1, 10=1.5, 11=2), [2] parity enable,
//                     [1] even parity
//   TX_EN_I   in   1  transmitter enable
//   BRK_I     in   1  send break: forces SO low while idle, holds off transfers
//   UDR_WE    in   1  one-cycle write strobe for UDR_I
//   UDR_I     in   8  data byte
//   SO        out  1  serial output, idle high
//   BE        out  1  buffer empty, UDR may be written
//   BE_PULSE  out  1  one-cycle pulse when the buffer is moved to the shifter
//   END_O     out  1  one-cycle pulse when a frame ends with nothing pending
// -----------------------------------------------------------------------------
module mfp_usart_tx #(
  parameter int unsigned DIV = 16
) (
  input  logic       XCLK_I,
  input  logic       RST,
  input  logic       TC_I,
  input  logic [7:0] UCR_I,
  input  logic       TX_EN_I,
  input  logic       BRK_I,
  input  logic       UDR_WE,
  input  logic [7:0] UDR_I,
  output logic       SO,
  output logic       BE,
  output logic       BE_PULSE,
  output logic       END_O
);

  localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(DIV - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(DIV / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Transmit clock synchroniser and edge detector.
  logic tc_s1_q, tc_s1_d;
  logic tc_s2_q, tc_s2_d;
  logic tc_s3_q, tc_s3_d;
  logic tc_edge_q, tc_edge_d;

  // Frame sequencing.
  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic          stop_cnt_q, stop_cnt_d;

  // Frame format latched at reload. The parity bit is also latched at reload.
  logic       pe_q, pe_d;
  logic       par_q, par_d;
  logic [1:0] stop_q, stop_d;
  logic       div_q, div_d;

  // Buffer and registered outputs.
  logic [7:0] udr_q, udr_d;
  logic       be_q, be_d;
  logic       be_pulse_q, be_pulse_d;
  logic       end_q, end_d;
  logic       so_q, so_d;

  logic       bit_tick;
  logic       half_tick;
  logic       stop_done;
  logic       can_load;
  logic       do_load;
  logic [7:0] wl_mask;
  logic       wl_parity;
  logic       ucr_unused;

  assign ucr_unused = UCR_I[0];

  // In divided mode one bit lasts DIV tc_edges. half_tick marks the midpoint
  // of a bit. It is used only to end a 1.5-stop frame.
  assign bit_tick  = tc_edge_q & (~div_q | (pre_q == PRE_MAX));
  assign half_tick = tc_edge_q & div_q & (pre_q == PRE_HALF);

  // 1.5 stop bits are only possible when divided. Undivided, they become 2.
  always_comb begin
    if (stop_q == 2'b10 && div_q) begin
      stop_done = half_tick & stop_cnt_q;
    end else if (stop_q[1]) begin
      stop_done = bit_tick & stop_cnt_q;
    end else begin
      stop_done = bit_tick;
    end
  end

  assign can_load  = TX_EN_I & ~be_q & ~BRK_I;

  // Parity covers only the configured word length. Unused high bits are masked.
  assign wl_mask   = 8'hFF >> UCR_I[6:5];
  assign wl_parity = ^(udr_q & wl_mask);

  always_comb begin
    // NOTE: every *_d first takes its hold value, so each path through this
    // block assigns every signal and no latch can be inferred.
    tc_s1_d    = TC_I;
    tc_s2_d    = tc_s1_q;
    tc_s3_d    = tc_s2_q;
    tc_edge_d  = tc_s2_q & ~tc_s3_q;
    state_d    = state_q;
    pre_d      = pre_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    stop_cnt_d = stop_cnt_q;
    pe_d       = pe_q;
    par_d      = par_q;
    stop_d     = stop_q;
    div_d      = div_q;
    udr_d      = udr_q;
    be_d       = be_q;
    be_pulse_d = 1'b0;
    end_d      = 1'b0;
    so_d       = so_q;
    do_load    = 1'b0;

    // The prescaler runs freely through the frame so that bit boundaries fall
    // every DIV tc_edges. It restarts at every reload.
    if (state_q != S_IDLE && div_q && tc_edge_q) begin
      pre_d = pre_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        pre_d   = '0;
        do_load = can_load;
      end
      S_START: begin
        if (bit_tick) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          if (bitcnt_q == 3'd0) begin
            state_d    = pe_q ? S_PARITY : S_STOP;
            stop_cnt_d = 1'b0;
          end else begin
            shreg_d  = {1'b0, shreg_q[7:1]};
            bitcnt_d = bitcnt_q - 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_tick) begin
          state_d    = S_STOP;
          stop_cnt_d = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          stop_cnt_d = 1'b1;
        end
        if (stop_done) begin
          if (can_load) begin
            do_load = 1'b1;
          end else begin
            state_d = S_IDLE;
            end_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Reload is shared by IDLE and by the end of STOP (back-to-back frames).
    if (do_load) begin
      state_d    = S_START;
      shreg_d    = udr_q;
      bitcnt_d   = 3'd7 - {1'b0, UCR_I[6:5]};
      pre_d      = '0;
      pe_d       = UCR_I[2];
      par_d      = UCR_I[1] ? wl_parity : ~wl_parity;
      stop_d     = UCR_I[4:3];
      div_d      = UCR_I[7];
      be_d       = 1'b1;
      be_pulse_d = 1'b1;
    end

    // A write always wins over the reload's BE set. The byte that was just
    // moved to the shifter is the old one, so nothing is lost.
    if (UDR_WE) begin
      udr_d = UDR_I;
      be_d  = 1'b0;
    end

    // SO is registered. It follows the state being entered.
    unique case (state_d)
      S_IDLE:   so_d = ~BRK_I;
      S_START:  so_d = 1'b0;
      S_DATA:   so_d = shreg_d[0];
      S_PARITY: so_d = par_q;
      S_STOP:   so_d = 1'b1;
      default:  so_d = 1'b1;
    endcase
  end

  always_ff @(posedge XCLK_I) begin
    if (RST) begin
      // NOTE: the data path (buffer, shifter, latched format) is reset along
      // with the control state. A pending byte is discarded, and nothing stale
      // can reach SO after reset.
      tc_s1_q    <= 1'b0;
      tc_s2_q    <= 1'b0;
      tc_s3_q    <= 1'b0;
      tc_edge_q  <= 1'b0;
      state_q    <= S_IDLE;
      pre_q      <= '0;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      stop_cnt_q <= 1'b0;
      pe_q       <= 1'b0;
      par_q      <= 1'b0;
      stop_q     <= '0;
      div_q      <= 1'b0;
      udr_q      <= '0;
      be_q       <= 1'b1;
      be_pulse_q <= 1'b0;
      end_q      <= 1'b0;
      so_q       <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments update all flops together at the edge.
      // Their order inside this block therefore has no effect.
      tc_s1_q    <= tc_s1_d;
      tc_s2_q    <= tc_s2_d;
      tc_s3_q    <= tc_s3_d;
      tc_edge_q  <= tc_edge_d;
      state_q    <= state_d;
      pre_q      <= pre_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      stop_cnt_q <= stop_cnt_d;
      pe_q       <= pe_d;
      par_q      <= par_d;
      stop_q     <= stop_d;
      div_q      <= div_d;
      udr_q      <= udr_d;
      be_q       <= be_d;
      be_pulse_q <= be_pulse_d;
      end_q      <= end_d;
      so_q       <= so_d;
    end
  end

  assign SO       = so_q;
  assign BE       = be_q;
  assign BE_PULSE = be_pulse_q;
  assign END_O    = end_q;

endmodule
